ahb_master_arb: RTL and testbench

AHB_MASTER_ARB -- requirements
Module: ahb_master_arb

---
 rtl/ahb_master_arb_pkg.sv | 19 +
 rtl/ahb_master_arb_arb_pick.sv | 24 ++
 rtl/ahb_master_arb.sv | 124 ++++++++++++
 tb/tb_ahb_master_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_arb_pkg.sv
// Shared types and bus constants for the AHB-Lite two-requester master.
package ahb_master_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/ahb_master_arb_arb_pick.sv
// Two-way request picker; gnt = {dm, if}, one-hot or zero.
// With RR_EN set, a tie goes to the owner named by prio; otherwise dm always wins a tie.
module arb_pick
   import ahb_master_arb_pkg::*;
#(
   parameter bit RR_EN = 1'b0
) (
   input  logic       if_req,
   input  logic       dm_req,
   input  owner_t     prio,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (if_req && dm_req) begin
         if (RR_EN && (prio == OWN_IF)) gnt = 2'b01;
         else                           gnt = 2'b10;
      end else begin
         gnt = {dm_req, if_req};
      end
   end

endmodule

// File: rtl/ahb_master_arb.sv
// AHB-Lite master shared by a fetch port and a data port, one transfer at a time.
// Define AHB_ARB_RR_EN to alternate simultaneous requests instead of fixed dm priority.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no transfer; grant a requester, latch its command
// ADDR    | NONSEQ address phase, waits for HREADY
// DATA    | data phase; completion on HREADY, done pulsed
module ahb_master_arb
   import ahb_master_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              dm_req,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              bus_err,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

`ifdef AHB_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   state_t            state, state_nxt;
   owner_t            owner, prio;
   logic [1:0]        pick;
   logic              xfer_end;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;

   arb_pick #(.RR_EN(RR_EN)) u_pick (
      .if_req (if_req),
      .dm_req (dm_req),
      .prio   (prio),
      .gnt    (pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if_gnt = pick[0] & ~rst;
            dm_gnt = pick[1] & ~rst;
            if (if_gnt || dm_gnt) state_nxt = ST_ADDR;
         end
         ST_ADDR: if (HREADY) state_nxt = ST_DATA;
         ST_DATA: if (HREADY) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Completion is visible in the same cycle HREADY ends the data phase,
   // so rdata bypasses HRDATA while done is high.
   assign xfer_end = (state == ST_DATA) && HREADY;
   assign if_done  = xfer_end && (owner == OWN_IF);
   assign dm_done  = xfer_end && (owner == OWN_DM);
   assign bus_err  = xfer_end && HRESP;
   assign if_rdata = if_done ? HRDATA : if_rdata_q;
   assign dm_rdata = dm_done ? HRDATA : dm_rdata_q;

   assign HTRANS = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HSIZE  = HSIZE_WORD;
   assign HADDR  = addr_q;
   assign HWRITE = write_q;
   assign HWDATA = wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= OWN_IF;
         prio       <= OWN_DM;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if (dm_gnt) begin
            owner   <= OWN_DM;
            prio    <= OWN_IF;
            addr_q  <= dm_addr;
            write_q <= dm_write;
            wdata_q <= dm_wdata;
         end else if (if_gnt) begin
            owner   <= OWN_IF;
            prio    <= OWN_DM;
            addr_q  <= if_addr;
            write_q <= 1'b0;
         end
         if (if_done) if_rdata_q <= HRDATA;
         if (dm_done) dm_rdata_q <= HRDATA;
      end
   end

endmodule

// File: tb/tb_ahb_master_arb.sv
// Self-checking bench for ahb_master_arb: vector table plus contention and reset sequences.
module tb_ahb_master_arb;
   import ahb_master_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_done;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_write, dm_gnt, dm_done, bus_err;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HREADY, HRESP;
   logic [2:0]  HSIZE;

   always #5 clk = ~clk;

   ahb_master_arb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_done(dm_done), .bus_err(bus_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   typedef struct {
      logic        own_dm;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        resp;
      int          wa;
      int          wd;
   } vec_t;

   typedef struct {
      logic        own_dm;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_if = '0;
   logic [31:0] last_dm = '0;
   vec_t        vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered at posedge+1 of the grant cycle; returns at posedge+1 of the following IDLE cycle.
   task automatic run_phases(input logic own_dm, input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic resp, input int wa, input int wd);
      exp_t e, got;
      e.own_dm = own_dm;
      e.rdata  = rdata;
      e.err    = resp;
      sb.push_back(e);
      step();
      if (own_dm) dm_req = 1'b0;
      else        if_req = 1'b0;
      for (int i = 0; i <= wa; i++) begin
         HREADY = (i == wa);
         @(negedge clk);
         chk("addr_htrans", HTRANS, HTRANS_NONSEQ);
         chk("addr_haddr", HADDR, addr);
         chk("addr_hwrite", HWRITE, wr);
         chk("addr_done", {if_done, dm_done, bus_err}, 3'b000);
         step();
      end
      for (int i = 0; i <= wd; i++) begin
         HREADY = (i == wd);
         HRDATA = (i == wd) ? rdata : (32'hBAD0_0000 + i);
         HRESP  = (i == wd) ? resp : 1'b0;
         @(negedge clk);
         chk("data_htrans", HTRANS, HTRANS_IDLE);
         if (wr) chk("data_hwdata", HWDATA, wdata);
         if (i < wd) begin
            chk("wait_done", {if_done, dm_done, bus_err}, 3'b000);
         end else if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
         end else begin
            got = sb.pop_front();
            chk("done_owner", {if_done, dm_done}, got.own_dm ? 2'b01 : 2'b10);
            chk("bus_err", bus_err, got.err);
            if (got.own_dm) begin
               chk("dm_rdata", dm_rdata, got.rdata);
               chk("if_rdata_hold", if_rdata, last_if);
               last_dm = got.rdata;
            end else begin
               chk("if_rdata", if_rdata, got.rdata);
               chk("dm_rdata_hold", dm_rdata, last_dm);
               last_if = got.rdata;
            end
         end
         step();
      end
      HRESP  = 1'b0;
      HREADY = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      if (v.own_dm) begin
         dm_req = 1'b1; dm_write = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
         if_addr = 32'hFFFF_FFF0;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
         dm_addr = 32'hEEEE_EEE0; dm_wdata = 32'h1111_2222;
      end
      HREADY = 1'b1;
      @(negedge clk);
      chk("gnt", {if_gnt, dm_gnt}, v.own_dm ? 2'b01 : 2'b10);
      chk("gnt_htrans", HTRANS, HTRANS_IDLE);
      run_phases(v.own_dm, v.addr, v.wr, v.wdata, v.rdata, v.resp, v.wa, v.wd);
      @(negedge clk);
      chk("idle_htrans", HTRANS, HTRANS_IDLE);
      chk("idle_haddr", HADDR, v.addr);
      chk("idle_hwrite", HWRITE, v.wr);
      chk("idle_pulses", {if_gnt, dm_gnt, if_done, dm_done, bus_err}, 5'b0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0013, 1'b0, 0, 0};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 0, 2};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_0001, 1'b1, 0, 0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'h55AA_55AA, 1'b0, 1, 1};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         32'h1234_5678, 1'b0, 2, 0};
      vecs[5] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,         32'h0000_0077, 1'b1, 0, 1};

      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h100;
      dm_req = 1'b1; dm_write = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h5;
      HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
      #12;
      chk("rst_htrans", HTRANS, 2'b00);
      chk("rst_hwrite", HWRITE, 1'b0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_hsize", HSIZE, 3'b010);
      chk("rst_gnt", {if_gnt, dm_gnt}, 2'b00);
      chk("rst_done", {if_done, dm_done, bus_err}, 3'b000);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);
      if_req = 1'b0; dm_req = 1'b0; dm_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Contention: dm wins first; the second tie depends on the arbitration mode.
      if_req = 1'b1; if_addr = 32'h200;
      dm_req = 1'b1; dm_write = 1'b0; dm_addr = 32'h300;
      @(negedge clk);
      chk("tie1_gnt", {if_gnt, dm_gnt}, 2'b01);
      run_phases(1'b1, 32'h300, 1'b0, 32'h0, 32'hA000_0001, 1'b0, 0, 0);
      dm_req = 1'b1; dm_addr = 32'h304;
      @(negedge clk);
`ifdef AHB_ARB_RR_EN
      chk("tie2_gnt", {if_gnt, dm_gnt}, 2'b10);
      run_phases(1'b0, 32'h200, 1'b0, 32'h0, 32'hB000_0002, 1'b0, 0, 0);
      @(negedge clk);
      chk("tie2_next_gnt", {if_gnt, dm_gnt}, 2'b01);
      run_phases(1'b1, 32'h304, 1'b0, 32'h0, 32'hC000_0003, 1'b0, 0, 0);
`else
      chk("tie2_gnt", {if_gnt, dm_gnt}, 2'b01);
      run_phases(1'b1, 32'h304, 1'b0, 32'h0, 32'hC000_0003, 1'b0, 0, 0);
      @(negedge clk);
      chk("tie2_next_gnt", {if_gnt, dm_gnt}, 2'b10);
      run_phases(1'b0, 32'h200, 1'b0, 32'h0, 32'hB000_0002, 1'b0, 0, 0);
`endif
      step();

      // Reset during a stalled data phase drops the transfer silently.
      dm_req = 1'b1; dm_write = 1'b0; dm_addr = 32'h400;
      HREADY = 1'b1;
      @(negedge clk);
      chk("rstx_gnt", {if_gnt, dm_gnt}, 2'b01);
      step();
      dm_req = 1'b0;
      @(negedge clk);
      chk("rstx_nonseq", HTRANS, HTRANS_NONSEQ);
      step();
      HREADY = 1'b0;
      HRDATA = 32'hDEAD_0000;
      HRESP  = 1'b1;
      @(negedge clk);
      chk("rstx_wait_done", {if_done, dm_done, bus_err}, 3'b000);
      rst = 1'b1;
      HREADY = 1'b1;
      #1;
      chk("rstx_htrans", HTRANS, 2'b00);
      chk("rstx_done", {if_done, dm_done, bus_err}, 3'b000);
      chk("rstx_haddr", HADDR, 32'h0);
      chk("rstx_dm_rdata", dm_rdata, 32'h0);
      chk("rstx_if_rdata", if_rdata, 32'h0);
      step();
      chk("rstx_held_done", {if_done, dm_done, bus_err}, 3'b000);
      HRESP = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_if = '0;
      last_dm = '0;
      step();
      run_vec(vecs[0]);
      run_vec(vecs[2]);

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
